// File: rtl/enc_pkg.sv
// Shared types and helpers for the request encoder / serializer family.
package enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } enc_state_t;

   // Widest request vector the shared priority helper handles.
   localparam int ENC_MAX_N = 64;

   function automatic int enc_prio(input logic [ENC_MAX_N-1:0] vec);
      int res;
      res = 0;
      for (int i = 0; i < ENC_MAX_N; i++) begin
         if (vec[i]) res = i;
      end
      return res;
   endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational N->W selector: highest set bit, searched downward from ptr with wrap.
// ptr = N-1 makes the rotate stage an identity, giving plain highest-index priority.
module prio_sel
   import enc_pkg::*;
#(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx
);

   logic [N-1:0]           rot;
   logic [ENC_MAX_N-1:0]   ext;
   logic [W-1:0]           pos;

   // rot[j] holds vec[ptr+1+j], so vec[ptr] lands at the top and wins first.
   always_comb begin
      rot = '0;
      for (int j = 0; j < N; j++) begin
         rot[j] = vec[ptr + W'(j) + W'(1)];
      end
      ext = '0;
      ext[N-1:0] = rot;
      pos = W'(enc_prio(ext));
      idx = ptr + pos + W'(1);
   end

endmodule

// File: rtl/enc_serializer.sv
// Sequential priority encoder: captures a request vector and emits one index per handshake.
// Optional ENC_RR_EN selects round-robin search via a persistent ptr register.
//
//   state | meaning
//   IDLE  | waiting for E && |I to capture a batch
//   EMIT  | presenting the selected pending index on O with V=1
module enc_serializer
   import enc_pkg::*;
#(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] I,
   input  logic         E,
   input  logic         ready,
   output logic [W-1:0] O,
   output logic         V,
   output logic         busy
);

   localparam logic [W-1:0] PTR_RST = W'(N - 1);

   enc_state_t    state, state_nxt;
   logic [N-1:0]  pend, pend_nxt;
   logic [W-1:0]  sel;
   logic [W-1:0]  ptr_eff;

`ifdef ENC_RR_EN
   logic [W-1:0]  ptr, ptr_nxt;

   assign ptr_eff = ptr;

   // Any presented code taken by the consumer moves ptr, including one taken during abort.
   always_comb begin
      ptr_nxt = ptr;
      if (state == EMIT && ready) ptr_nxt = sel - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) ptr <= PTR_RST;
      else     ptr <= ptr_nxt;
   end
`else
   assign ptr_eff = PTR_RST;
`endif

   prio_sel #(.N(N)) u_prio_sel (
      .vec (pend),
      .ptr (ptr_eff),
      .idx (sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      case (state)
         IDLE: begin
            if (E && (|I)) begin
               pend_nxt  = I;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (!E) begin
               pend_nxt  = '0;
               state_nxt = IDLE;
            end else if (ready) begin
               pend_nxt[sel] = 1'b0;
               if (pend_nxt == '0) state_nxt = IDLE;
            end
         end
         default: begin
            pend_nxt  = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign V    = (state == EMIT);
   assign busy = (state == EMIT);
   assign O    = (state == EMIT) ? sel : '0;

endmodule
